// File: rtl/monitor_pkg.sv
// Shared definitions for the triggered capture monitor: capture FSM states and read pipeline depth.
package monitor_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int RD_LAT = 2;

endpackage

// File: rtl/monitor_dpram.sv
// Simple dual-port capture RAM: one write port, one read port with registered address and data.
module monitor_dpram #(
  parameter string ID         = "NONE",
  parameter int    ADDR_WIDTH = 11,
  parameter int    WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef IS_ALTERA
  altsyncram #(
    .operation_mode                     ("DUAL_PORT"),
    .width_a                            (WIDTH),
    .widthad_a                          (ADDR_WIDTH),
    .numwords_a                         (DEPTH),
    .width_b                            (WIDTH),
    .widthad_b                          (ADDR_WIDTH),
    .numwords_b                         (DEPTH),
    .address_reg_b                      ("CLOCK0"),
    .rdcontrol_reg_b                    ("CLOCK0"),
    .outdata_reg_b                      ("CLOCK0"),
    .read_during_write_mode_mixed_ports ("DONT_CARE"),
    .lpm_type                           ("altsyncram"),
    .lpm_hint                           ({"INSTANCE_NAME=", ID})
  ) u_ram (
    .clock0    (clk),
    .wren_a    (we),
    .address_a (wr_addr),
    .data_a    (wr_data),
    .address_b (rd_addr),
    .q_b       (rd_data)
  );
`else
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  // NOTE: the array has no reset; clearing it would stop RAM inference and cost DEPTH cycles anyway.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_addr_q <= rd_addr;
    rd_data   <= mem[rd_addr_q];
  end
`endif

endmodule

// File: rtl/capture_ram_monitor.sv
// Triggered capture buffer: records one selected channel circularly around a trigger event,
// then freezes for readback indexed from the oldest retained sample.
module capture_ram_monitor
  import monitor_pkg::*;
#(
  parameter string ID         = "NONE",
  parameter int    ADDR_WIDTH = 11,
  parameter int    WIDTH      = 32,
  parameter int    CHANNELS   = 4,
  parameter int    SEL_WIDTH  = 2,
  parameter int    PRE_TRIG   = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] ch_data,
  input  logic                      in_valid,
  input  logic [SEL_WIDTH-1:0]      ch_sel,
  input  logic                      arm,
  input  logic                      trigger,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_WIDTH-1:0]     trig_addr
);

  localparam int                    DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PRE_TRIG_A = ADDR_WIDTH'(PRE_TRIG);
  localparam logic [ADDR_WIDTH-1:0] POST_INIT  = ADDR_WIDTH'(DEPTH - PRE_TRIG - 1);

  state_t                state, state_n;
  logic [SEL_WIDTH-1:0]  sel_q, sel_n;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_n;
  logic [ADDR_WIDTH-1:0] fill, fill_n;
  logic [ADDR_WIDTH-1:0] post, post_n;
  logic [ADDR_WIDTH-1:0] trig_addr_n;
  logic                  wr_req;

  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [WIDTH-1:0]      wr_data_q;

  logic [RD_LAT-1:0]     rd_pipe;
  logic [ADDR_WIDTH-1:0] rd_phys;
  logic [WIDTH-1:0]      ram_q;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    sel_n       = sel_q;
    wr_ptr_n    = wr_ptr;
    fill_n      = fill;
    post_n      = post;
    trig_addr_n = trig_addr;
    wr_req      = 1'b0;

    if (arm) begin
      // Out-of-range selects fall back to channel 0; a same-cycle sample is dropped.
      sel_n    = (int'(ch_sel) < CHANNELS) ? ch_sel : '0;
      wr_ptr_n = '0;
      fill_n   = '0;
      state_n  = (PRE_TRIG == 0) ? S_ARMED : S_PRETRIG;
    end else if (in_valid) begin
      unique case (state)
        S_PRETRIG: begin
          wr_req   = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          fill_n   = fill + 1'b1;
          if (fill_n == PRE_TRIG_A) state_n = S_ARMED;
        end
        S_ARMED: begin
          wr_req   = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          if (trigger) begin
            trig_addr_n = wr_ptr;
            post_n      = POST_INIT;
            state_n     = (POST_INIT == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          wr_req   = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          post_n   = post - 1'b1;
          if (post_n == '0) state_n = S_DONE;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sel_q     <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      post      <= '0;
      trig_addr <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_pipe   <= '0;
    end else begin
      state     <= state_n;
      sel_q     <= sel_n;
      wr_ptr    <= wr_ptr_n;
      fill      <= fill_n;
      post      <= post_n;
      trig_addr <= trig_addr_n;
      wr_en_q   <= wr_req;
      wr_addr_q <= wr_ptr;
      wr_data_q <= ch_data[int'(sel_q)*WIDTH +: WIDTH];
      rd_pipe   <= {rd_pipe[RD_LAT-2:0], rd_en};
    end
  end

  // Readback index 0 is the oldest retained sample, PRE_TRIG slots before the trigger.
  assign rd_phys  = trig_addr - PRE_TRIG_A + rd_addr;
  assign rd_valid = rd_pipe[RD_LAT-1];
  assign rd_data  = rd_valid ? ram_q : '0;
  assign busy     = (state == S_PRETRIG) || (state == S_ARMED) || (state == S_POST);
  assign done     = (state == S_DONE);

  monitor_dpram #(
    .ID         (ID),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (WIDTH)
  ) u_ram (
    .clk     (clk),
    .we      (wr_en_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_data_q),
    .rd_addr (rd_phys),
    .rd_data (ram_q)
  );

endmodule

// File: tb/tb_capture_ram_monitor.sv
// Directed bench for capture_ram_monitor: a PRE_TRIG=4 instance plus a PRE_TRIG=0 instance on shared inputs.
module tb_capture_ram_monitor;
  import monitor_pkg::*;

  localparam int AW = 4;
  localparam int W  = 32;
  localparam int CH = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH*W-1:0] ch_data;
  logic          in_valid, arm, trigger, rd_en;
  logic [SW-1:0] ch_sel;
  logic [AW-1:0] rd_addr;

  logic [W-1:0]  rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1, busy0, busy1, done0, done1;
  logic [AW-1:0] trig_addr0, trig_addr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  capture_ram_monitor #(
    .ID("TAP_A"), .ADDR_WIDTH(AW), .WIDTH(W), .CHANNELS(CH), .SEL_WIDTH(SW), .PRE_TRIG(4)
  ) dut0 (
    .clk(clk), .rst(rst), .ch_data(ch_data), .in_valid(in_valid), .ch_sel(ch_sel),
    .arm(arm), .trigger(trigger), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0), .done(done0), .trig_addr(trig_addr0)
  );

  capture_ram_monitor #(
    .ID("TAP_B"), .ADDR_WIDTH(AW), .WIDTH(W), .CHANNELS(CH), .SEL_WIDTH(SW), .PRE_TRIG(0)
  ) dut1 (
    .clk(clk), .rst(rst), .ch_data(ch_data), .in_valid(in_valid), .ch_sel(ch_sel),
    .arm(arm), .trigger(trigger), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1), .done(done1), .trig_addr(trig_addr1)
  );

  function automatic logic [CH*W-1:0] pack(input int n);
    logic [CH*W-1:0] v;
    for (int k = 0; k < CH; k++) v[k*W +: W] = 32'(k * 256 + n);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int first, input int last, input int trig_a, input int trig_b);
    for (int n = first; n <= last; n++) begin
      ch_data  = pack(n);
      in_valid = 1'b1;
      trigger  = (n == trig_a) || (n == trig_b);
      step();
    end
    in_valid = 1'b0;
    trigger  = 1'b0;
  endtask

  task automatic arm_capture(input logic [SW-1:0] sel);
    arm    = 1'b1;
    ch_sel = sel;
    step();
    arm = 1'b0;
  endtask

  // One isolated read: returns rd_valid after the first and second edges plus the data from both instances.
  task automatic read_one(input int a, output logic v1, output logic v2,
                          output logic [W-1:0] d0, output logic [W-1:0] d1);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    step();
    v1    = rd_valid0;
    rd_en = 1'b0;
    step();
    v2 = rd_valid0;
    d0 = rd_data0;
    d1 = rd_data1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; arm = 1'b0; trigger = 1'b0; rd_en = 1'b0;
    ch_sel = '0; rd_addr = '0; ch_data = '0;
    step();
    step();
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || rd_valid0 !== 1'b0 || rd_data0 !== '0 || trig_addr0 !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b rd_valid=%0b rd_data=%h trig_addr=%0d, expected all 0",
               busy0, done0, rd_valid0, rd_data0, trig_addr0);
    end
    checks++;
    if (dut0.state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dut0.state, S_IDLE);
    end
    rst = 1'b0;
    stream(0, 4, 2, -1);
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || dut0.wr_en_q !== 1'b0 || dut0.wr_ptr !== '0) begin
      errors++;
      $display("FAIL idle_ignores_valid: got busy=%0b done=%0b wr_en=%0b wr_ptr=%0d, expected 0 0 0 0",
               busy0, done0, dut0.wr_en_q, dut0.wr_ptr);
    end
  endtask

  task automatic test_capture();
    logic v1, v2;
    logic [W-1:0] d0, d1;
    arm_capture(2'd2);
    checks++;
    if (busy0 !== 1'b1 || dut0.state !== S_PRETRIG) begin
      errors++;
      $display("FAIL arm_busy: got busy=%0b state=%0d expected busy=1 state=%0d", busy0, dut0.state, S_PRETRIG);
    end
    stream(0, 30, 20, -1);
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL early_done: after n=30 got done=%0b busy=%0b expected 0 1", done0, busy0);
    end
    stream(31, 31, -1, -1);
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || trig_addr0 !== 4'd4) begin
      errors++;
      $display("FAIL capture_done: got done=%0b busy=%0b trig_addr=%0d expected 1 0 4", done0, busy0, trig_addr0);
    end
    for (int r = 0; r < 16; r++) begin
      read_one(r, v1, v2, d0, d1);
      checks++;
      if (v1 !== 1'b0 || v2 !== 1'b1 || d0 !== 32'h210 + 32'(r)) begin
        errors++;
        $display("FAIL capture_read[%0d]: got v1=%0b v2=%0b data=%h expected 0 1 %h",
                 r, v1, v2, d0, 32'h210 + 32'(r));
      end
    end
  endtask

  task automatic test_pretrig_ignore();
    logic v1, v2;
    logic [W-1:0] d0, d1;
    arm_capture(2'd2);
    stream(0, 20, 1, 9);
    checks++;
    if (done0 !== 1'b1 || trig_addr0 !== 4'd9) begin
      errors++;
      $display("FAIL pretrig_ignore_done: got done=%0b trig_addr=%0d expected 1 9", done0, trig_addr0);
    end
    read_one(0, v1, v2, d0, d1);
    checks++;
    if (v2 !== 1'b1 || d0 !== 32'h205) begin
      errors++;
      $display("FAIL pretrig_ignore_rd0: got valid=%0b data=%h expected 1 00000205", v2, d0);
    end
    read_one(4, v1, v2, d0, d1);
    checks++;
    if (v2 !== 1'b1 || d0 !== 32'h209) begin
      errors++;
      $display("FAIL pretrig_ignore_rd4: got valid=%0b data=%h expected 1 00000209", v2, d0);
    end
  endtask

  task automatic test_rearm();
    logic v1, v2;
    logic [W-1:0] d0, d1;
    arm_capture(2'd2);
    stream(0, 11, 6, -1);
    checks++;
    if (dut0.state !== S_POST) begin
      errors++;
      $display("FAIL rearm_in_post: got state=%0d expected %0d", dut0.state, S_POST);
    end
    // Re-arm with a valid sample in the same cycle: the sample must be dropped.
    ch_data = pack(12); in_valid = 1'b1; arm = 1'b1; ch_sel = 2'd1;
    step();
    arm = 1'b0; in_valid = 1'b0;
    checks++;
    if (dut0.state !== S_PRETRIG || dut0.wr_ptr !== '0 || dut0.wr_en_q !== 1'b0 || busy0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL rearm_restart: got state=%0d wr_ptr=%0d wr_en=%0b busy=%0b done=%0b expected %0d 0 0 1 0",
               dut0.state, dut0.wr_ptr, dut0.wr_en_q, busy0, done0, S_PRETRIG);
    end
    stream(40, 55, 45, -1);
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("FAIL rearm_early_done: got done=%0b expected 0", done0);
    end
    stream(56, 56, -1, -1);
    checks++;
    if (done0 !== 1'b1 || trig_addr0 !== 4'd5) begin
      errors++;
      $display("FAIL rearm_done: got done=%0b trig_addr=%0d expected 1 5", done0, trig_addr0);
    end
    for (int i = 0; i < 3; i++) begin
      int r;
      r = (i == 0) ? 0 : (i == 1) ? 4 : 15;
      read_one(r, v1, v2, d0, d1);
      checks++;
      if (v2 !== 1'b1 || d0 !== 32'h100 + 32'(41 + r)) begin
        errors++;
        $display("FAIL rearm_read[%0d]: got valid=%0b data=%h expected 1 %h", r, v2, d0, 32'h100 + 32'(41 + r));
      end
    end
  endtask

  task automatic test_reset_mid();
    arm_capture(2'd3);
    stream(0, 8, 5, -1);
    checks++;
    if (dut0.state !== S_POST) begin
      errors++;
      $display("FAIL reset_mid_setup: got state=%0d expected %0d", dut0.state, S_POST);
    end
    rd_en = 1'b1; rd_addr = '0;
    step();
    rd_en = 1'b0; rst = 1'b1;
    step();
    checks++;
    if (dut0.state !== S_IDLE || busy0 !== 1'b0 || done0 !== 1'b0 || rd_valid0 !== 1'b0 || trig_addr0 !== '0) begin
      errors++;
      $display("FAIL reset_mid: got state=%0d busy=%0b done=%0b rd_valid=%0b trig_addr=%0d expected 0 0 0 0 0",
               dut0.state, busy0, done0, rd_valid0, trig_addr0);
    end
    rst = 1'b0;
    step();
    checks++;
    if (rd_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read_cancel: got rd_valid=%0b expected 0", rd_valid0);
    end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    arm_capture(2'd3);
    stream(0, 31, 20, -1);
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_setup: got done=%0b expected 1", done0);
    end
    for (int j = 0; j < 18; j++) begin
      logic exp_v;
      rd_en   = (j < 16);
      rd_addr = AW'(j);
      step();
      exp_v = (j >= 1) && (j <= 16);
      if (rd_valid0 === 1'b1) nvalid++;
      checks++;
      if (rd_valid0 !== exp_v || (exp_v && rd_data0 !== 32'h310 + 32'(j - 1))) begin
        errors++;
        $display("FAIL b2b_cycle[%0d]: got valid=%0b data=%h expected valid=%0b data=%h",
                 j, rd_valid0, rd_data0, exp_v, 32'h310 + 32'(j - 1));
      end
    end
    rd_en = 1'b0;
    checks++;
    if (nvalid != 16) begin
      errors++;
      $display("FAIL b2b_count: got %0d valid beats expected 16", nvalid);
    end
  endtask

  task automatic test_pretrig_zero();
    logic v1, v2;
    logic [W-1:0] d0, d1;
    arm_capture(2'd1);
    checks++;
    if (busy1 !== 1'b1 || dut1.state !== S_ARMED) begin
      errors++;
      $display("FAIL zero_pre_arm: got busy=%0b state=%0d expected 1 %0d", busy1, dut1.state, S_ARMED);
    end
    stream(0, 14, 0, -1);
    checks++;
    if (done1 !== 1'b0) begin
      errors++;
      $display("FAIL zero_pre_early_done: got done=%0b expected 0", done1);
    end
    stream(15, 15, -1, -1);
    checks++;
    if (done1 !== 1'b1 || trig_addr1 !== '0) begin
      errors++;
      $display("FAIL zero_pre_done: got done=%0b trig_addr=%0d expected 1 0", done1, trig_addr1);
    end
    read_one(0, v1, v2, d0, d1);
    checks++;
    if (rd_valid1 !== 1'b1 || d1 !== 32'h100) begin
      errors++;
      $display("FAIL zero_pre_rd0: got valid=%0b data=%h expected 1 00000100", rd_valid1, d1);
    end
    read_one(15, v1, v2, d0, d1);
    checks++;
    if (d1 !== 32'h10F) begin
      errors++;
      $display("FAIL zero_pre_rd15: got data=%h expected 0000010f", d1);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_pretrig_ignore();
    test_rearm();
    test_reset_mid();
    test_back_to_back();
    test_pretrig_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
